inta_cycle_sequencer: RTL and testbench

//  CPU-side interrupt-acknowledge sequencer for the 8259A PIC. Watches PIC INT, runs the 8086-style
//  two-pulse INTA_n bus cycle with programmable pulse/gap timing, and captures the vector byte the
//  PIC drives during the second pulse. Hands the vector to the core via valid/ready.

---
 rtl/inta_cycle_sequencer_pkg.sv | 30 +++
 rtl/inta_cycle_sequencer_pulse_timer.sv | 37 +++
 rtl/inta_cycle_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_inta_cycle_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inta_cycle_sequencer_pkg.sv
// Shared definitions for the interrupt-acknowledge sequencer.
//   - State encoding for the sequencer FSM (IDLE..HOLDOFF)
//   - Default timing constants
//   - Active level of the INTA_n strobe
//   - Helper to size the shared down-counter
package inta_cycle_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_PULSE1  = 3'd1;
  localparam state_t ST_GAP     = 3'd2;
  localparam state_t ST_PULSE2  = 3'd3;
  localparam state_t ST_DELIVER = 3'd4;
  localparam state_t ST_HOLDOFF = 3'd5;

  localparam int DEF_PULSE_CYCLES   = 4;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // Level driven on inta_n while acknowledging.
  localparam logic INTA_ACTIVE = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/inta_cycle_sequencer_pulse_timer.sv
// Loadable down-counter shared by every timed state of the sequencer.
// The counter stops at 1, so 'expired' stays asserted until the next load.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load         load load_val this cycle (takes priority over counting)
//   en           count enable
//   load_val     value loaded on 'load'
//   value        current count
//   expired      count has reached 1 (last cycle of the timed interval)
module inta_cycle_sequencer_pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expired
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (en && (value_q > CNT_W'(1))) begin
      value_q <= value_q - CNT_W'(1);
    end
  end

  assign value   = value_q;
  assign expired = (value_q == CNT_W'(1));

endmodule

// File: rtl/inta_cycle_sequencer.sv
// CPU-side interrupt-acknowledge sequencer for an 8259A PIC.
// Watches the PIC INT line, runs the two-pulse INTA_n cycle and captures the
// vector byte the PIC drives during the second pulse, then hands it to the
// core over a valid/ready handshake.
//
// Optional feature: define INTA_VECTOR_TIMEOUT_EN to drop an undelivered
// vector after TIMEOUT_CYCLES DELIVER cycles (vector_timeout pulses once).
// Without it DELIVER waits indefinitely and vector_timeout is tied low.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   int_in          PIC INT (same clock domain)
//   int_enable      CPU interrupt enable, gates only the start of a sequence
//   data_bus_in     PIC data bus (vector valid during the 2nd INTA_n pulse)
//   inta_n          interrupt acknowledge to PIC, active low, registered
//   vector_out      captured vector byte
//   vector_valid    vector_out holds an undelivered vector
//   vector_ready    consumer accepts the vector when high with vector_valid
//   busy            high in every state except IDLE
//   vector_timeout  one-cycle pulse when a vector is dropped on timeout
//
// Timing: the FSM state leads the registered outputs by one cycle, so
// inta_n follows the state one edge later and the vector is captured at the
// edge that ends the last low cycle of the second pulse.
module inta_cycle_sequencer
  import inta_cycle_sequencer_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_in,
  input  logic       int_enable,
  input  logic [7:0] data_bus_in,
  output logic       inta_n,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic       busy,
  output logic       vector_timeout
);

  localparam int CNT_W = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

  state_t     state_q, state_d;
  logic       inta_n_q, inta_n_d;
  logic [7:0] vector_out_q, vector_out_d;
  logic       vector_valid_q, vector_valid_d;
  logic       busy_q, busy_d;

  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expired;

  logic xfer;
  logic tmo;

  // Vector handed over at this edge.
  assign xfer = (state_q == ST_DELIVER) && vector_valid_q && vector_ready;

`ifdef INTA_VECTOR_TIMEOUT_EN
  logic vector_timeout_q, vector_timeout_d;

  // Transfer on the final cycle wins over the timeout.
  assign tmo    = (state_q == ST_DELIVER) && vector_valid_q && tmr_expired && !vector_ready;
  // The capture cycle is not counted, so the vector is offered for exactly
  // TIMEOUT_CYCLES cycles.
  assign tmr_en = !((state_q == ST_DELIVER) && !vector_valid_q);
`else
  assign tmo    = 1'b0;
  assign tmr_en = 1'b1;
`endif

  inta_cycle_sequencer_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .expired  (tmr_expired)
  );

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      inta_n_q       <= ~INTA_ACTIVE;
      vector_out_q   <= 8'h00;
      vector_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef INTA_VECTOR_TIMEOUT_EN
      vector_timeout_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      inta_n_q       <= inta_n_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
      busy_q         <= busy_d;
`ifdef INTA_VECTOR_TIMEOUT_EN
      vector_timeout_q <= vector_timeout_d;
`endif
    end
  end

  // Next-state logic. Once started a sequence always runs to completion;
  // int_in/int_enable are only looked at in IDLE.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal (no latches).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (int_in && int_enable) state_d = ST_PULSE1;
      ST_PULSE1:  if (tmr_expired)          state_d = ST_GAP;
      ST_GAP:     if (tmr_expired)          state_d = ST_PULSE2;
      ST_PULSE2:  if (tmr_expired)          state_d = ST_DELIVER;
      ST_DELIVER: if (xfer || tmo)          state_d = ST_HOLDOFF;
      ST_HOLDOFF: if (tmr_expired)          state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // The timer is reloaded on every state entry with the length of the new state.
  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = '0;
    unique case (state_d)
      ST_PULSE1, ST_PULSE2: tmr_load_val = CNT_W'(PULSE_CYCLES);
      ST_GAP, ST_HOLDOFF:   tmr_load_val = CNT_W'(GAP_CYCLES);
`ifdef INTA_VECTOR_TIMEOUT_EN
      ST_DELIVER:           tmr_load_val = CNT_W'(TIMEOUT_CYCLES);
`endif
      default:              tmr_load_val = '0;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    inta_n_d       = ((state_q == ST_PULSE1) || (state_q == ST_PULSE2)) ? INTA_ACTIVE : ~INTA_ACTIVE;
    busy_d         = (state_d != ST_IDLE);
    vector_out_d   = vector_out_q;
    vector_valid_d = vector_valid_q;
`ifdef INTA_VECTOR_TIMEOUT_EN
    vector_timeout_d = 1'b0;
`endif
    if (state_q == ST_DELIVER) begin
      if (!vector_valid_q) begin
        // First DELIVER cycle: inta_n is still low on the second pulse here.
        vector_out_d   = data_bus_in;
        vector_valid_d = 1'b1;
      end else if (xfer) begin
        vector_valid_d = 1'b0;
      end else if (tmo) begin
        vector_valid_d = 1'b0;
`ifdef INTA_VECTOR_TIMEOUT_EN
        vector_timeout_d = 1'b1;
`endif
      end
    end
  end

  assign inta_n       = inta_n_q;
  assign vector_out   = vector_out_q;
  assign vector_valid = vector_valid_q;
  assign busy         = busy_q;
`ifdef INTA_VECTOR_TIMEOUT_EN
  assign vector_timeout = vector_timeout_q;
`else
  assign vector_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_inta_cycle_sequencer.sv
// Self-checking bench for inta_cycle_sequencer. A small PIC model drives the
// vector on the data bus only while inta_n is low on the second pulse;
// expected vectors are queued when a sequence is started and compared when
// the DUT hands them over. Honours INTA_VECTOR_TIMEOUT_EN for the timeout test.
module tb_inta_cycle_sequencer;

  localparam int TB_PULSE   = 4;
  localparam int TB_GAP     = 2;
  localparam int TB_TIMEOUT = 8;
`ifdef INTA_VECTOR_TIMEOUT_EN
  localparam int HOLD2 = 6;
`else
  localparam int HOLD2 = 30;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       int_in;
  logic       int_enable;
  logic [7:0] data_bus_in;
  logic       inta_n;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic       vector_ready;
  logic       busy;
  logic       vector_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int xfers    = 0;
  int drops    = 0;
  int pulse_cnt  = 0;
  int pulse_base = 0;
  logic [7:0] pic_vec = 8'h00;
  logic [7:0] exp_q[$];

  inta_cycle_sequencer #(
    .PULSE_CYCLES   (TB_PULSE),
    .GAP_CYCLES     (TB_GAP),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .int_in         (int_in),
    .int_enable     (int_enable),
    .data_bus_in    (data_bus_in),
    .inta_n         (inta_n),
    .vector_out     (vector_out),
    .vector_valid   (vector_valid),
    .vector_ready   (vector_ready),
    .busy           (busy),
    .vector_timeout (vector_timeout)
  );

  always #5 clk = ~clk;

  // PIC model: vector on the bus only during the second INTA_n pulse.
  always @(negedge inta_n) pulse_cnt++;
  assign data_bus_in = (!inta_n && (pulse_cnt - pulse_base == 2)) ? pic_vec : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: compare on transfer, retire on timeout drop.
  always @(negedge clk) begin
    if (!reset && vector_valid && vector_ready) begin
      xfers++;
      if (exp_q.size() == 0) check("sb_unexpected_xfer", 1, 0);
      else                   check("sb_vector", {24'h0, vector_out}, {24'h0, exp_q.pop_front()});
    end
    if (!reset && vector_timeout) begin
      drops++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [7:0] v);
    pic_vec    = v;
    pulse_base = pulse_cnt;
    exp_q.push_back(v);
    int_in = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (!vector_valid && n < limit) begin
      tick();
      n++;
    end
    check(tag, vector_valid, 1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int ok;
    int hi;
    int x0;
    logic tmo_seen;

    reset = 1'b1; int_in = 1'b0; int_enable = 1'b0; vector_ready = 1'b0;
    repeat (3) tick();
    check("rst_inta_n", inta_n, 1);
    check("rst_vector_out", vector_out, 8'h00);
    check("rst_valid", vector_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", vector_timeout, 0);
    reset = 1'b0;
    tick();

    // 1: basic sequence with exact cycle timing relative to the sample edge.
    int_enable = 1'b1; vector_ready = 1'b1;
    start_seq(8'h48);
    tick();                               // sample edge E
    check("t1_inta_k0", inta_n, 1);
    check("t1_busy_k0", busy, 1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 2) int_in = 1'b0;
      check($sformatf("t1_inta_k%0d", k), inta_n,
            ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) ? 1'b0 : 1'b1);
      check($sformatf("t1_valid_k%0d", k), vector_valid, (k == 11));
      check($sformatf("t1_busy_k%0d", k), busy, (k <= 13));
      if (k == 11) check("t1_vector", vector_out, 8'h48);
    end

    // 2: consumer stalls; vector held stable, then exactly one transfer.
    vector_ready = 1'b0;
    start_seq(8'h48);
    wait_valid("t2_valid_timeout", 40);
    int_in = 1'b0;
    ok = 0;
    for (int i = 0; i < HOLD2; i++) begin
      tick();
      if (vector_valid && vector_out == 8'h48) ok++;
    end
    check("t2_stable_cycles", ok, HOLD2);
    x0 = xfers;
    vector_ready = 1'b1;
    repeat (6) tick();
    check("t2_single_xfer", xfers - x0, 1);
    check("t2_valid_dropped", vector_valid, 0);
    wait_idle("t2_idle_timeout", 20);

    // 3: interrupts disabled; nothing happens until enable rises.
    int_enable = 1'b0;
    int_in = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (inta_n && !busy) ok++;
    end
    check("t3_disabled_quiet", ok, 20);
    start_seq(8'h21);
    int_enable = 1'b1;
    tick();
    check("t3_busy_after_enable", busy, 1);
    tick();
    check("t3_inta_low", inta_n, 0);
    int_in = 1'b0;
    wait_valid("t3_valid_timeout", 20);
    wait_idle("t3_idle_timeout", 20);

    // 4: reset during PULSE2, then a fresh sequence with int_in still high.
    pic_vec = 8'h33;
    pulse_base = pulse_cnt;
    int_in = 1'b1;
    tick();                               // sample edge
    repeat (7) tick();                    // inside second pulse
    check("t4_in_pulse2", inta_n, 0);
    reset = 1'b1;
    tick();
    check("t4_rst_inta_n", inta_n, 1);
    check("t4_rst_valid", vector_valid, 0);
    check("t4_rst_busy", busy, 0);
    reset = 1'b0;
    start_seq(8'h34);
    wait_valid("t4_valid_timeout", 30);
    int_in = 1'b0;
    wait_idle("t4_idle_timeout", 20);

    // 5: INT and enable drop during GAP; sequence still completes (IR7 spurious).
    start_seq(8'h4F);
    tick();
    repeat (5) tick();
    int_in = 1'b0;
    int_enable = 1'b0;
    wait_valid("t5_valid_timeout", 20);
    wait_idle("t5_idle_timeout", 20);
    int_enable = 1'b1;

    // 6: undelivered vector.
    vector_ready = 1'b0;
    start_seq(8'h5A);
    tick();
    int_in = 1'b0;
    wait_valid("t6_valid_timeout", 20);
    x0 = xfers;
`ifdef INTA_VECTOR_TIMEOUT_EN
    hi = 1;
    tmo_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vector_valid) hi++;
      else begin
        tmo_seen = vector_timeout;
        break;
      end
    end
    check("t6_valid_cycles", hi, TB_TIMEOUT);
    check("t6_timeout_pulse", tmo_seen, 1);
    tick();
    check("t6_timeout_1cycle", vector_timeout, 0);
    check("t6_drop_count", drops, 1);
    check("t6_no_xfer", xfers - x0, 0);
    vector_ready = 1'b1;
    wait_idle("t6_idle_timeout", 20);
`else
    hi = 0;
    tmo_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (vector_valid && vector_out == 8'h5A) hi++;
      if (vector_timeout) tmo_seen = 1'b1;
    end
    check("t6_valid_held", hi, 100);
    check("t6_no_timeout", tmo_seen, 0);
    vector_ready = 1'b1;
    repeat (3) tick();
    check("t6_late_xfer", xfers - x0, 1);
    wait_idle("t6_idle_timeout", 20);
`endif

    repeat (3) tick();
    check("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
